// File: rtl/imem_loader_pkg.sv
// Shared loader definitions: state encodings and frame geometry.
// Used by imem_loader and ldr_word_pack.
package imem_loader_pkg;

  localparam int LDR_HDR_BYTES  = 2;
  localparam int LDR_WORD_BYTES = 4;
  localparam int LDR_BCNT_W     = $clog2(LDR_WORD_BYTES);

  typedef enum logic [2:0] {
    LDR_S_HDR0 = 3'd0,
    LDR_S_HDR1 = 3'd1,
    LDR_S_DATA = 3'd2,
    LDR_S_WR   = 3'd3,
    LDR_S_CHK  = 3'd4,
    LDR_S_DONE = 3'd5,
    LDR_S_ERR  = 3'd6
  } ldr_state_e;

endpackage

// File: rtl/imem_loader_word_pack.sv
// Packs accepted bytes MSB-first into a 32-bit word; word_vld_o strobes
// combinationally on the cycle the last byte of a word is accepted.
module ldr_word_pack
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_acc_i,
  input  logic [7:0]  byte_i,
  output logic        word_vld_o,
  output logic [31:0] word_o
);

  logic [23:0]           shift_q, shift_d;
  logic [LDR_BCNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (byte_acc_i) begin
      shift_d = {shift_q[15:0], byte_i};
      cnt_d   = cnt_q + 1'b1;
    end
  end

  assign word_vld_o = byte_acc_i && (cnt_q == LDR_BCNT_W'(LDR_WORD_BYTES - 1));
  assign word_o     = {shift_q, byte_i};

  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Host byte stream -> instr_mem write port loader, holds the core until loaded.
// Optional trailing XOR checksum byte enabled by LDR_CHKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_vld_ldr_i,
  input  logic [7:0]  byte_ldr_i,
  output logic        byte_rdy_ldr_o,
  output logic        wr_en_imem_ldr_o,
  output logic [31:0] addr_imem_ldr_o,
  output logic [31:0] wr_instr_imem_ldr_o,
  output logic        cpu_run_ldr_o,
  output logic        done_ldr_o,
  output logic        err_ldr_o
);

  localparam int          IDX_W       = $clog2(MAX_WORDS) + 1;
  localparam logic [31:0] MAX_WORDS_U = 32'(MAX_WORDS);
`ifdef LDR_CHKSUM_EN
  localparam ldr_state_e  S_LAST      = LDR_S_CHK;
`else
  localparam ldr_state_e  S_LAST      = LDR_S_DONE;
`endif

  ldr_state_e        state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  idx_inc;
  logic              wr_en_q, wr_en_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [15:0]       n_full;
  logic              byte_rdy;
  logic              byte_acc;
  logic              word_vld;
  logic [31:0]       word_packed;
`ifdef LDR_CHKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign byte_rdy = reset && (state_q == LDR_S_HDR0 || state_q == LDR_S_HDR1 ||
                              state_q == LDR_S_DATA || state_q == LDR_S_CHK);
  assign byte_acc = byte_vld_ldr_i && byte_rdy;
  assign n_full   = {n_q[15:8], byte_ldr_i};
  assign idx_inc  = idx_q + 1'b1;

  ldr_word_pack u_pack (
    .clk        (clk),
    .reset      (reset),
    .byte_acc_i (byte_acc && (state_q == LDR_S_DATA)),
    .byte_i     (byte_ldr_i),
    .word_vld_o (word_vld),
    .word_o     (word_packed)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef LDR_CHKSUM_EN
    xor_d   = xor_q;
    if (byte_acc && state_q != LDR_S_CHK) xor_d = xor_q ^ byte_ldr_i;
`endif
    case (state_q)
      LDR_S_HDR0: begin
        if (byte_acc) begin
          n_d     = {byte_ldr_i, 8'h00};
          state_d = LDR_S_HDR1;
        end
      end
      LDR_S_HDR1: begin
        if (byte_acc) begin
          n_d = n_full;
          if (n_full == 16'd0)                  state_d = S_LAST;
          else if ({16'd0, n_full} > MAX_WORDS_U) state_d = LDR_S_ERR;
          else                                  state_d = LDR_S_DATA;
        end
      end
      LDR_S_DATA: begin
        // Write strobe is registered, so it is high exactly for the WR cycle.
        if (word_vld) begin
          wr_en_d = 1'b1;
          addr_d  = BASE_ADDR + (32'(idx_q) << 2);
          data_d  = word_packed;
          state_d = LDR_S_WR;
        end
      end
      LDR_S_WR: begin
        idx_d   = idx_inc;
        state_d = (32'(idx_inc) == 32'(n_q)) ? S_LAST : LDR_S_DATA;
      end
`ifdef LDR_CHKSUM_EN
      LDR_S_CHK: begin
        if (byte_acc) state_d = (byte_ldr_i == xor_q) ? LDR_S_DONE : LDR_S_ERR;
      end
`endif
      LDR_S_DONE: state_d = LDR_S_DONE;
      LDR_S_ERR:  state_d = LDR_S_ERR;
      default:    state_d = LDR_S_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= LDR_S_HDR0;
      n_q     <= '0;
      idx_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef LDR_CHKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef LDR_CHKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  assign byte_rdy_ldr_o      = byte_rdy;
  assign wr_en_imem_ldr_o    = wr_en_q;
  assign addr_imem_ldr_o     = addr_q;
  assign wr_instr_imem_ldr_o = data_q;
  assign done_ldr_o          = (state_q == LDR_S_DONE);
  assign cpu_run_ldr_o       = (state_q == LDR_S_DONE);
  assign err_ldr_o           = (state_q == LDR_S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued when frames are
// built and checked as the DUT pulses its write strobe.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        byte_vld = 1'b0;
  logic [7:0]  byte_d = 8'h00;
  logic        byte_rdy;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] data;
  logic        cpu_run;
  logic        done;
  logic        err;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] cks;
  wr_t        mon_e;
  int         tests_run = 0;
  int         tests_failed = 0;
  int         writes = 0;
  int         w0;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(1024)) dut (
    .clk                 (clk),
    .reset               (reset),
    .byte_vld_ldr_i      (byte_vld),
    .byte_ldr_i          (byte_d),
    .byte_rdy_ldr_o      (byte_rdy),
    .wr_en_imem_ldr_o    (wr_en),
    .addr_imem_ldr_o     (addr),
    .wr_instr_imem_ldr_o (data),
    .cpu_run_ldr_o       (cpu_run),
    .done_ldr_o          (done),
    .err_ldr_o           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    tests_run++;
    tests_failed++;
    $error("FAIL %s: observed timeout/unexpected event expected none", tag);
  endtask

  // Write monitor: each strobe is one transaction.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      writes++;
      if (exp_q.size() == 0) begin
        fail_now("unexpected_write");
      end else begin
        mon_e = exp_q.pop_front();
        $display("[TB] write addr=0x%08h data=0x%08h", addr, data);
        chk("wr_addr", addr, mon_e.addr);
        chk("wr_data", data, mon_e.data);
        chk("rdy_low_in_wr", 32'(byte_rdy), 32'd0);
      end
    end
  end

  task automatic new_frame();
    tx_q.delete();
    cks = 8'h00;
  endtask

  task automatic push_byte(input logic [7:0] b);
    tx_q.push_back(b);
    cks = cks ^ b;
  endtask

  task automatic push_hdr(input logic [15:0] n);
    push_byte(n[15:8]);
    push_byte(n[7:0]);
  endtask

  task automatic push_word(input int idx, input logic [31:0] w);
    wr_t e;
    push_byte(w[31:24]);
    push_byte(w[23:16]);
    push_byte(w[15:8]);
    push_byte(w[7:0]);
    e.addr = BASE + 32'(idx) * 32'd4;
    e.data = w;
    exp_q.push_back(e);
  endtask

  task automatic finish_frame();
`ifdef LDR_CHKSUM_EN
    tx_q.push_back(cks);
`endif
  endtask

  // Holds vld until the byte is taken; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    byte_vld = 1'b1;
    byte_d   = b;
    @(negedge clk);
    while (byte_rdy !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      fail_now("byte_accept_timeout");
      byte_vld = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      byte_vld = 1'b0;
      $display("[TB] byte 0x%02h accepted", b);
    end
  endtask

  task automatic send_all(input int max_gap);
    int g;
    foreach (tx_q[i]) begin
      send_byte(tx_q[i]);
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      if (g > 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_final();
    int guard;
    guard = 0;
    @(negedge clk);
    while (done !== 1'b1 && err !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) fail_now("final_state_timeout");
  endtask

  task automatic apply_reset(input bit check);
    byte_vld = 1'b0;
    reset    = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (check) begin
      chk("rst_rdy", 32'(byte_rdy), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_addr", addr, 32'd0);
      chk("rst_data", data, 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_run", 32'(cpu_run), 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    apply_reset(1'b1);
    @(negedge clk);
    chk("post_rst_rdy", 32'(byte_rdy), 32'd1);
    @(posedge clk);
    #1;

    // Two-word back-to-back load
    w0 = writes;
    new_frame();
    push_hdr(16'd2);
    push_word(0, 32'h2008_0005);
    push_word(1, 32'h8C09_0004);
    finish_frame();
    send_all(0);
    wait_final();
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_run", 32'(cpu_run), 32'd1);
    chk("t2_err", 32'(err), 32'd0);
    chk("t2_rdy", 32'(byte_rdy), 32'd0);
    chk("t2_writes", 32'(writes - w0), 32'd2);
    chk("t2_pending", 32'(exp_q.size()), 32'd0);
    chk("t2_addr_hold", addr, 32'h0000_0004);
    chk("t2_data_hold", data, 32'h8C09_0004);

    // Empty image
    apply_reset(1'b0);
    w0 = writes;
    new_frame();
    push_hdr(16'd0);
    finish_frame();
    send_all(0);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_run", 32'(cpu_run), 32'd1);
    chk("t3_rdy", 32'(byte_rdy), 32'd0);
    @(negedge clk);
    chk("t3_writes", 32'(writes - w0), 32'd0);

    // Largest legal count is accepted
    apply_reset(1'b0);
    new_frame();
    push_hdr(16'd1024);
    send_all(0);
    chk("t4a_err", 32'(err), 32'd0);
    chk("t4a_rdy", 32'(byte_rdy), 32'd1);

    // Oversized count
    apply_reset(1'b0);
    w0 = writes;
    new_frame();
    push_hdr(16'h0401);
    send_all(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_run", 32'(cpu_run), 32'd0);
    chk("t4_done", 32'(done), 32'd0);
    chk("t4_rdy", 32'(byte_rdy), 32'd0);
    chk("t4_writes", 32'(writes - w0), 32'd0);
    @(posedge clk);
    #1;

    // Three words with random gaps
    apply_reset(1'b0);
    w0 = writes;
    new_frame();
    push_hdr(16'd3);
    for (int i = 0; i < 3; i++) push_word(i, $urandom);
    finish_frame();
    send_all(3);
    wait_final();
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_writes", 32'(writes - w0), 32'd3);
    chk("t5_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // Abort mid-word, then reload one word
    apply_reset(1'b0);
    w0 = writes;
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    apply_reset(1'b1);
    chk("t6_abort_writes", 32'(writes - w0), 32'd0);
    new_frame();
    push_hdr(16'd1);
    push_word(0, 32'h1234_5678);
    finish_frame();
    send_all(1);
    wait_final();
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_writes", 32'(writes - w0), 32'd1);
    chk("t6_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;

`ifdef LDR_CHKSUM_EN
    // Correct checksum byte
    apply_reset(1'b0);
    new_frame();
    push_hdr(16'd1);
    push_word(0, 32'h1122_3344);
    finish_frame();
    send_all(0);
    wait_final();
    chk("t7_done", 32'(done), 32'd1);
    chk("t7_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;

    // Corrupted checksum byte
    apply_reset(1'b0);
    new_frame();
    push_hdr(16'd1);
    push_word(0, 32'h1122_3344);
    tx_q.push_back(cks ^ 8'h01);
    send_all(0);
    wait_final();
    chk("t8_err", 32'(err), 32'd1);
    chk("t8_run", 32'(cpu_run), 32'd0);
    chk("t8_done", 32'(done), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
